// File: rtl/lfsr_offset_finder.sv
// lfsr_offset_finder: loads a seed and feedback polynomial, then advances a
// Fibonacci-style LFSR one shift per clock until its state matches a target
// word. It reports the number of steps taken, or a timeout after MAX_ITER
// compares.
//
// Optional feature: defining LFSR_MATCH_MASK_EN adds the match_mask input.
// The match then only compares the bits that are set in the mask.
//
// Ports
//   clk_72MHz   in   system clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   start       in   start pulse, sampled only while idle
//   abort       in   level, returns the engine to idle from any state
//   polynomial  in   feedback taps, captured at start
//   start_data  in   seed, captured at start
//   target      in   word to search for, captured at start
//   match_mask  in   compare mask, captured at start (LFSR_MATCH_MASK_EN only)
//   busy        out  high while loading and searching
//   done        out  one-cycle pulse when a search ends
//   found       out  1 = match, 0 = timeout; held until the next start
//   offset      out  step index of the match (MAX_ITER on timeout)
//   value       out  current LFSR state
module lfsr_offset_finder #(
  parameter int unsigned WIDTH    = 17,
  parameter int unsigned MAX_ITER = 131071,
  parameter int unsigned CNT_W    = 17
) (
  input  logic             clk_72MHz,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] polynomial,
  input  logic [WIDTH-1:0] start_data,
  input  logic [WIDTH-1:0] target,
`ifdef LFSR_MATCH_MASK_EN
  input  logic [WIDTH-1:0] match_mask,
`endif
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [CNT_W-1:0] offset,
  output logic [WIDTH-1:0] value
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MAX_ITER - 1);
  localparam logic [CNT_W-1:0] TIMEOUT   = CNT_W'(MAX_ITER);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SEARCH,
    S_DONE
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_poly, w_poly_nxt;
  logic [WIDTH-1:0] r_seed, w_seed_nxt;
  logic [WIDTH-1:0] r_target, w_target_nxt;
  logic [WIDTH-1:0] r_value, w_value_nxt;
  logic [CNT_W-1:0] r_iter, w_iter_nxt;
  logic [CNT_W-1:0] r_offset, w_offset_nxt;
  logic             r_found, w_found_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic             w_match;
  logic [WIDTH-1:0] w_step;

`ifdef LFSR_MATCH_MASK_EN
  logic [WIDTH-1:0] r_mask, w_mask_nxt;
  assign w_match = ((r_value ^ r_target) & r_mask) == '0;
`else
  assign w_match = (r_value == r_target);
`endif

  // One LFSR shift: move left and feed the parity of the tapped bits into the LSB.
  assign w_step = {r_value[WIDTH-2:0], ^(r_value & r_poly)};

  // Next-state and next-register logic. Abort overrides every transition.
  always_comb begin
    w_state_nxt  = r_state;
    w_poly_nxt   = r_poly;
    w_seed_nxt   = r_seed;
    w_target_nxt = r_target;
    w_value_nxt  = r_value;
    w_iter_nxt   = r_iter;
    w_offset_nxt = r_offset;
    w_found_nxt  = r_found;
    w_done_nxt   = 1'b0;
`ifdef LFSR_MATCH_MASK_EN
    w_mask_nxt   = r_mask;
`endif
    if (abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            w_poly_nxt   = polynomial;
            w_seed_nxt   = start_data;
            w_target_nxt = target;
`ifdef LFSR_MATCH_MASK_EN
            w_mask_nxt   = match_mask;
`endif
            w_found_nxt  = 1'b0;
            w_offset_nxt = '0;
            w_state_nxt  = S_LOAD;
          end
        end
        S_LOAD: begin
          w_value_nxt = r_seed;
          w_iter_nxt  = '0;
          w_state_nxt = S_SEARCH;
        end
        S_SEARCH: begin
          if (w_match) begin
            w_found_nxt  = 1'b1;
            w_offset_nxt = r_iter;
            w_state_nxt  = S_DONE;
          end else if (r_iter == LAST_ITER) begin
            w_found_nxt  = 1'b0;
            w_offset_nxt = TIMEOUT;
            w_state_nxt  = S_DONE;
          end else begin
            w_value_nxt = w_step;
            w_iter_nxt  = r_iter + CNT_W'(1);
          end
        end
        S_DONE: begin
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
    w_busy_nxt = (w_state_nxt == S_LOAD) || (w_state_nxt == S_SEARCH);
  end

  // State and datapath registers.
  always_ff @(posedge clk_72MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_poly   <= '0;
      r_seed   <= '0;
      r_target <= '0;
      r_value  <= '0;
      r_iter   <= '0;
      r_offset <= '0;
      r_found  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
`ifdef LFSR_MATCH_MASK_EN
      r_mask   <= '0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_poly   <= w_poly_nxt;
      r_seed   <= w_seed_nxt;
      r_target <= w_target_nxt;
      r_value  <= w_value_nxt;
      r_iter   <= w_iter_nxt;
      r_offset <= w_offset_nxt;
      r_found  <= w_found_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
`ifdef LFSR_MATCH_MASK_EN
      r_mask   <= w_mask_nxt;
`endif
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign found  = r_found;
  assign offset = r_offset;
  assign value  = r_value;

endmodule

// File: tb/tb_lfsr_offset_finder.sv
// Testbench for lfsr_offset_finder. It drives directed and random searches and
// compares the results against a sequence model kept inside the bench.
module tb_lfsr_offset_finder;

  localparam int unsigned W     = 17;
  localparam int unsigned MAXI  = 16;
  localparam int unsigned CW    = 17;
  localparam int          BOUND = 200;

  logic          clk_72MHz = 1'b0;
  logic          reset_n;
  logic          start, abort;
  logic [W-1:0]  polynomial, start_data, target, match_mask;
  logic          busy, done, found;
  logic [CW-1:0] offset;
  logic [W-1:0]  value;

  int n_checks = 0;
  int n_errors = 0;

  lfsr_offset_finder #(.WIDTH(W), .MAX_ITER(MAXI), .CNT_W(CW)) dut (
    .clk_72MHz (clk_72MHz),
    .reset_n   (reset_n),
    .start     (start),
    .abort     (abort),
    .polynomial(polynomial),
    .start_data(start_data),
    .target    (target),
`ifdef LFSR_MATCH_MASK_EN
    .match_mask(match_mask),
`endif
    .busy      (busy),
    .done      (done),
    .found     (found),
    .offset    (offset),
    .value     (value)
  );

  always #5 clk_72MHz = ~clk_72MHz;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // The LFSR state after k shifts from seed s.
  function automatic logic [W-1:0] state_after(input logic [W-1:0] p, input logic [W-1:0] s, input int k);
    logic [W-1:0] v;
    v = s;
    for (int i = 0; i < k; i++) v = {v[W-2:0], ^(v & p)};
    return v;
  endfunction

  // Reference result: the first step index among MAXI candidates whose state matches under the mask.
  task automatic model(input logic [W-1:0] p, input logic [W-1:0] s, input logic [W-1:0] t,
                       input logic [W-1:0] m, output logic f, output int off);
    f   = 1'b0;
    off = MAXI;
    for (int i = 0; i < MAXI; i++) begin
      if (!f && (((state_after(p, s, i) ^ t) & m) == '0)) begin
        f   = 1'b1;
        off = i;
      end
    end
  endtask

  // Runs one search. It pulses start, scrambles the inputs and start while the
  // search runs, and waits for done. Latency is counted in edges after the edge that sampled start.
  task automatic run_search(input logic [W-1:0] p, input logic [W-1:0] s, input logic [W-1:0] t,
                            input logic [W-1:0] m, output logic ok, output logic f,
                            output int off, output int lat);
    polynomial = p; start_data = s; target = t; match_mask = m; start = 1'b1;
    @(posedge clk_72MHz); #1;
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    ok  = 1'b0;
    lat = 0;
    for (int e = 1; e <= BOUND && !ok; e++) begin
      @(posedge clk_72MHz); #1;
      if (done) begin
        ok  = 1'b1;
        lat = e;
      end else begin
        polynomial = W'($urandom); start_data = W'($urandom);
        target     = W'($urandom); match_mask = W'($urandom);
        start      = 1'($urandom);
      end
    end
    start = 1'b0;
    f   = found;
    off = int'(offset);
    chk("done_seen", 32'(ok), 32'd1);
    if (ok) begin
      @(posedge clk_72MHz); #1;
      chk("done_one_cycle", 32'(done), 32'd0);
    end
  endtask

  // Runs a search and checks found and offset against the model, plus latency when a match is found.
  task automatic search_and_check(input string tag, input logic [W-1:0] p, input logic [W-1:0] s,
                                  input logic [W-1:0] t, input logic [W-1:0] m);
    logic ok, f, ef;
    int   off, lat, eoff;
    model(p, s, t, m, ef, eoff);
    run_search(p, s, t, m, ok, f, off, lat);
    chk({tag, "_found"}, 32'(f), 32'(ef));
    chk({tag, "_offset"}, 32'(off), 32'(eoff));
    if (ok && ef) chk({tag, "_latency"}, 32'(lat), 32'(eoff + 3));
  endtask

  localparam logic [W-1:0] POLY = 17'h1D258;
  localparam logic [W-1:0] ONES = '1;

  initial begin
    logic         ok, f;
    int           off, lat, k;
    logic [W-1:0] p, s, t, m;

    reset_n = 1'b0; start = 1'b0; abort = 1'b0;
    polynomial = '0; start_data = '0; target = '0; match_mask = ONES;
    repeat (3) @(negedge clk_72MHz);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_found", 32'(found), 32'd0);
    chk("rst_offset", 32'(offset), 32'd0);
    chk("rst_value", 32'(value), 32'd0);
    reset_n = 1'b1;
    @(negedge clk_72MHz);

    // Directed searches.
    run_search(POLY, 17'h00001, 17'h00001, ONES, ok, f, off, lat);
    chk("seed_eq_found", 32'(f), 32'd1);
    chk("seed_eq_offset", 32'(off), 32'd0);
    chk("seed_eq_latency", 32'(lat), 32'd3);

    run_search(POLY, 17'h00001, state_after(POLY, 17'h00001, 5), ONES, ok, f, off, lat);
    chk("step5_found", 32'(f), 32'd1);
    chk("step5_offset", 32'(off), 32'd5);
    chk("step5_latency", 32'(lat), 32'd8);

    run_search(POLY, 17'h00000, 17'h00001, ONES, ok, f, off, lat);
    chk("seed0_found", 32'(f), 32'd0);
    chk("seed0_offset", 32'(off), 32'(MAXI));

    run_search(POLY, 17'h00000, 17'h00000, ONES, ok, f, off, lat);
    chk("seed0_tgt0_found", 32'(f), 32'd1);
    chk("seed0_tgt0_offset", 32'(off), 32'd0);

    // start together with abort while idle leaves the engine idle.
    @(negedge clk_72MHz);
    start = 1'b1; abort = 1'b1;
    @(posedge clk_72MHz); #1;
    start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", 32'(busy), 32'd0);

    // Abort at SEARCH iteration 3: busy drops at the next edge and no done follows.
    polynomial = POLY; start_data = 17'h00000; target = 17'h00001; match_mask = ONES; start = 1'b1;
    @(posedge clk_72MHz); #1;
    start = 1'b0;
    repeat (4) @(posedge clk_72MHz);
    #1;
    chk("abort_busy_before", 32'(busy), 32'd1);
    abort = 1'b1;
    @(posedge clk_72MHz); #1;
    abort = 1'b0;
    chk("abort_busy_drop", 32'(busy), 32'd0);
    ok = 1'b0;
    repeat (MAXI + 6) begin
      @(posedge clk_72MHz); #1;
      if (done) ok = 1'b1;
    end
    chk("abort_no_done", 32'(ok), 32'd0);
    chk("abort_found_kept", 32'(found), 32'd0);
    chk("abort_offset_kept", 32'(offset), 32'd0);
    search_and_check("after_abort", POLY, 17'h0ABCD, 17'h0ABCD, ONES);

    // Reset asserted in the middle of a search.
    polynomial = POLY; start_data = 17'h00000; target = 17'h00001; start = 1'b1;
    @(posedge clk_72MHz); #1;
    start = 1'b0;
    repeat (3) @(posedge clk_72MHz);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_value", 32'(value), 32'd0);
    chk("midrst_offset", 32'(offset), 32'd0);
    ok = 1'b0;
    repeat (4) begin
      @(posedge clk_72MHz); #1;
      if (done) ok = 1'b1;
    end
    chk("midrst_no_done", 32'(ok), 32'd0);
    @(negedge clk_72MHz);
    reset_n = 1'b1;
    @(negedge clk_72MHz);

`ifdef LFSR_MATCH_MASK_EN
    // Low-byte mask: find a poly/seed whose low byte first repeats the step-9 value at step 9.
    m = 17'h000FF;
    p = POLY; s = 17'h00001;
    for (int tr = 0; tr < 500; tr++) begin
      model(p, s, state_after(p, s, 9), m, f, off);
      if (off == 9) break;
      p = W'($urandom) | 17'h10000;
      s = W'($urandom);
    end
    chk("mask_model_9", 32'(off), 32'd9);
    search_and_check("mask_low_byte", p, s, state_after(p, s, 9), m);
    search_and_check("mask_zero", POLY, 17'h00001, 17'h1FFFF, 17'h00000);
`endif

    // Random searches against the model.
    for (int n = 0; n < 40; n++) begin
      p = W'($urandom) | 17'h10000;
      s = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      k = $urandom_range(0, 20);
      t = ($urandom_range(0, 3) == 0) ? W'($urandom) : state_after(p, s, k);
`ifdef LFSR_MATCH_MASK_EN
      m = ($urandom_range(0, 1) == 0) ? ONES : W'($urandom);
`else
      m = ONES;
`endif
      search_and_check("rand", p, s, t, m);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
